// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: byte-level I2C master (START / WRITE / READ / STOP) with
// open-drain SCL/SDA, clock stretching and a valid/ready command interface.
module i2c_master_ctrl #(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic [7:0] cmd_data,
  input  logic       cmd_nack,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_ack,
  output logic       busy,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV + 2);
  localparam logic [CNT_W-1:0] QLAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] RLAST = CNT_W'(CLK_DIV + 1);

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] CMD_STOP  = 2'b11;

  typedef enum logic [3:0] {
    IDLE,
    START_Q0, START_Q1, START_Q2, START_Q3,
    BIT_P0, BIT_P1, BIT_P2, BIT_P3,
    STOP_Q0, STOP_Q1, STOP_Q2, STOP_Q3,
    DONE
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       bit_q;
  logic [1:0]       cmd_q;
  logic [7:0]       data_q;
  logic             nack_q;
  logic [7:0]       shift_q;
  logic             ack_smp_q;
  logic             scl_meta_q, scl_sync_q, sda_meta_q, sda_sync_q;

  logic released_c, cnt_step_c, quarter_end_c;

  // SDA level driven in bit slot idx (slot 8 is the ACK slot)
  function automatic logic bit_level(input logic [1:0] c, input logic [7:0] d,
                                     input logic n, input logic [3:0] idx);
    logic lvl;
    lvl = 1'b1;
    if (idx == 4'd8) begin
      lvl = (c == CMD_READ) ? n : 1'b1;
    end else if (c == CMD_WRITE) begin
      lvl = d[3'(4'd7 - idx)];
    end
    return lvl;
  endfunction

  // Two-flop synchronizers for the pad levels; idle bus reads high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_i;
      scl_sync_q <= scl_meta_q;
      sda_meta_q <= sda_i;
      sda_sync_q <= sda_meta_q;
    end
  end

  // Quarter timing: released quarters wait out the synchronizer, then count only while SCL is high
  always_comb begin
    released_c    = 1'b0;
    cnt_step_c    = 1'b1;
    quarter_end_c = (cnt_q == QLAST);
    if ((state_q == START_Q1) || (state_q == BIT_P1) || (state_q == STOP_Q1)) begin
      released_c = 1'b1;
    end
    if (released_c) begin
      cnt_step_c    = (cnt_q < CNT_W'(2)) || scl_sync_q;
      quarter_end_c = (cnt_q == RLAST) && scl_sync_q;
    end
  end

  // Command FSM with registered bus and response outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      cmd_q     <= CMD_START;
      data_q    <= '0;
      nack_q    <= 1'b0;
      shift_q   <= '0;
      ack_smp_q <= 1'b1;
      scl_o     <= 1'b1;
      sda_o     <= 1'b1;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_ack   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if ((state_q != IDLE) && (state_q != DONE)) begin
        if (quarter_end_c) begin
          cnt_q <= '0;
        end else if (cnt_step_c) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          if (cmd_valid && cmd_ready) begin
            cmd_q     <= cmd;
            data_q    <= cmd_data;
            nack_q    <= cmd_nack;
            cnt_q     <= '0;
            bit_q     <= '0;
            cmd_ready <= 1'b0;
            if (cmd == CMD_START) begin
              state_q <= START_Q0;
              sda_o   <= 1'b1;
            end else if (!busy) begin
              // No bus owned: complete immediately without touching the lines
              state_q   <= DONE;
              cmd_ready <= 1'b1;
              rsp_valid <= 1'b1;
              rsp_ack   <= 1'b0;
            end else if (cmd == CMD_STOP) begin
              state_q <= STOP_Q0;
              scl_o   <= 1'b0;
              sda_o   <= 1'b0;
            end else begin
              state_q <= BIT_P0;
              scl_o   <= 1'b0;
              sda_o   <= bit_level(cmd, cmd_data, cmd_nack, 4'd0);
            end
          end
        end
        START_Q0: if (quarter_end_c) begin state_q <= START_Q1; scl_o <= 1'b1; end
        START_Q1: if (quarter_end_c) begin state_q <= START_Q2; sda_o <= 1'b0; end
        START_Q2: if (quarter_end_c) begin state_q <= START_Q3; scl_o <= 1'b0; end
        START_Q3: if (quarter_end_c) begin
          state_q   <= DONE;
          busy      <= 1'b1;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b1;
          rsp_ack   <= 1'b0;
        end
        BIT_P0: if (quarter_end_c) begin state_q <= BIT_P1; scl_o <= 1'b1; end
        BIT_P1: if (quarter_end_c) begin state_q <= BIT_P2; end
        BIT_P2: if (quarter_end_c) begin
          state_q <= BIT_P3;
          scl_o   <= 1'b0;
          if (bit_q == 4'd8) begin
            ack_smp_q <= sda_sync_q;
          end else begin
            shift_q <= {shift_q[6:0], sda_sync_q};
          end
        end
        BIT_P3: if (quarter_end_c) begin
          if (bit_q == 4'd8) begin
            state_q   <= DONE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_ack   <= (cmd_q == CMD_WRITE) && !ack_smp_q;
            if (cmd_q == CMD_READ) begin
              rsp_data <= shift_q;
            end
          end else begin
            state_q <= BIT_P0;
            bit_q   <= bit_q + 4'd1;
            sda_o   <= bit_level(cmd_q, data_q, nack_q, bit_q + 4'd1);
          end
        end
        STOP_Q0: if (quarter_end_c) begin state_q <= STOP_Q1; scl_o <= 1'b1; end
        STOP_Q1: if (quarter_end_c) begin state_q <= STOP_Q2; end
        STOP_Q2: if (quarter_end_c) begin state_q <= STOP_Q3; sda_o <= 1'b1; end
        STOP_Q3: if (quarter_end_c) begin
          state_q   <= DONE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b1;
          rsp_ack   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl with CLK_DIV=4 and a bus-level responder model.
module tb_i2c_master_ctrl;

  localparam logic [1:0] C_START = 2'b00;
  localparam logic [1:0] C_WRITE = 2'b01;
  localparam logic [1:0] C_READ  = 2'b10;
  localparam logic [1:0] C_STOP  = 2'b11;
  localparam int LIMIT = 2000;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd;
  logic [7:0] cmd_data;
  logic       cmd_nack;
  logic       rsp_valid, rsp_ack, busy;
  logic [7:0] rsp_data;
  logic       scl_o, sda_o;

  // Responder model: mode 0 silent, 1 ACKs a written byte, 2 returns resp_byte
  int         resp_mode;
  logic [7:0] resp_byte;
  int         rcnt;
  int         drv_idx;
  logic       stretch_en;
  logic       resp_scl = 1'b1;
  logic       resp_sda;
  wire        scl_line = scl_o & resp_scl;
  wire        sda_line = sda_o & resp_sda;

  int total, bad;
  int start_cnt = 0, stop_cnt = 0, line_evt = 0;
  logic bits_q[$];

  i2c_master_ctrl #(.CLK_DIV(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .cmd_data(cmd_data), .cmd_nack(cmd_nack),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ack(rsp_ack), .busy(busy),
    .scl_i(scl_line), .sda_i(sda_line), .scl_o(scl_o), .sda_o(sda_o)
  );

  always #5 clk = ~clk;

  function automatic logic resp_level(input int mode, input logic [7:0] b, input int k);
    logic lvl;
    lvl = 1'b1;
    if (mode == 1 && k == 8) lvl = 1'b0;
    if (mode == 2 && k >= 0 && k < 8) lvl = b[3'(7 - k)];
    return lvl;
  endfunction

  assign resp_sda = resp_level(resp_mode, resp_byte, drv_idx);

  always @(posedge scl_line) begin
    rcnt = rcnt + 1;
    bits_q.push_back(sda_line);
  end
  always @(negedge scl_line) drv_idx = rcnt;
  always @(negedge sda_line) if (scl_line) start_cnt = start_cnt + 1;
  always @(posedge sda_line) if (scl_line) stop_cnt = stop_cnt + 1;
  always @(scl_o or sda_o) line_evt = line_evt + 1;

  // Stretch: hold SCL low for 50 extra cycles after the master releases it in bit 3
  always @(negedge scl_line) begin
    if (stretch_en && rcnt == 3) begin
      resp_scl = 1'b0;
      @(posedge scl_o);
      repeat (50) @(posedge clk);
      #1 resp_scl = 1'b1;
      stretch_en = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic arm(input int mode, input logic [7:0] b, input logic st);
    resp_mode  = mode;
    resp_byte  = b;
    rcnt       = 0;
    drv_idx    = 0;
    stretch_en = st;
    bits_q.delete();
  endtask

  task automatic send_cmd(input logic [1:0] c, input logic [7:0] d, input logic n,
                          output int lat, output int wait_n, output logic rdy_after);
    @(negedge clk);
    cmd_valid = 1'b1; cmd = c; cmd_data = d; cmd_nack = n;
    wait_n = 0;
    while (!cmd_ready && wait_n < LIMIT) begin @(negedge clk); wait_n++; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rdy_after = cmd_ready;
    lat = 0;
    while (!rsp_valid && lat < LIMIT) begin @(posedge clk); #1; lat++; end
    if (!rsp_valid) lat = -1;
  endtask

  function automatic logic [7:0] bits_byte();
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) if (bits_q.size() > i) v = {v[6:0], bits_q[i]};
    return v;
  endfunction

  task automatic test_reset();
    #12;
    total++; if ({scl_o, sda_o} !== 2'b11) begin bad++; $display("FAIL reset_lines got=%b exp=11", {scl_o, sda_o}); end
    total++; if ({cmd_ready, rsp_valid, rsp_ack, busy} !== 4'b1000) begin bad++; $display("FAIL reset_ctrl got=%b exp=1000", {cmd_ready, rsp_valid, rsp_ack, busy}); end
    total++; if (rsp_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", rsp_data); end
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_idle_cmd(input logic [1:0] c, input string nm);
    int lat, wn, ev0; logic rdy; logic [7:0] d0;
    ev0 = line_evt; d0 = rsp_data;
    send_cmd(c, 8'h5A, 1'b0, lat, wn, rdy);
    total++; if (lat !== 0) begin bad++; $display("FAIL %s_idle_lat got=%0d exp=0", nm, lat); end
    total++; if (rsp_ack !== 1'b0) begin bad++; $display("FAIL %s_idle_ack got=%b exp=0", nm, rsp_ack); end
    total++; if (rsp_data !== d0) begin bad++; $display("FAIL %s_idle_data got=%h exp=%h", nm, rsp_data, d0); end
    repeat (5) @(posedge clk); #1;
    total++; if (line_evt !== ev0) begin bad++; $display("FAIL %s_idle_lines toggles got=%0d exp=0", nm, line_evt - ev0); end
  endtask

  task automatic test_start_write_ack();
    int lat, wn, s0; logic rdy;
    s0 = start_cnt;
    send_cmd(C_START, 8'h00, 1'b0, lat, wn, rdy);
    total++; if (lat !== 18) begin bad++; $display("FAIL start_lat got=%0d exp=18", lat); end
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL start_ready_drop got=%b exp=0", rdy); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL start_busy got=%b exp=1", busy); end
    total++; if (start_cnt - s0 !== 1) begin bad++; $display("FAIL start_cond got=%0d exp=1", start_cnt - s0); end
    total++; if ({scl_o, sda_o} !== 2'b00) begin bad++; $display("FAIL start_lines got=%b exp=00", {scl_o, sda_o}); end
    arm(1, 8'h00, 1'b0);
    send_cmd(C_WRITE, 8'h94, 1'b0, lat, wn, rdy);
    total++; if (lat !== 162) begin bad++; $display("FAIL write_lat got=%0d exp=162", lat); end
    total++; if (rsp_ack !== 1'b1) begin bad++; $display("FAIL write_ack got=%b exp=1", rsp_ack); end
    total++; if (bits_q.size() !== 9) begin bad++; $display("FAIL write_nbits got=%0d exp=9", bits_q.size()); end
    total++; if (bits_byte() !== 8'h94) begin bad++; $display("FAIL write_bits got=%h exp=94", bits_byte()); end
  endtask

  task automatic test_write_nack_stop();
    int lat, wn, p0; logic rdy;
    arm(0, 8'h00, 1'b0);
    send_cmd(C_WRITE, 8'h40, 1'b0, lat, wn, rdy);
    total++; if (lat !== 162) begin bad++; $display("FAIL nack_lat got=%0d exp=162", lat); end
    total++; if (rsp_ack !== 1'b0) begin bad++; $display("FAIL nack_ack got=%b exp=0", rsp_ack); end
    total++; if (bits_q.size() < 9 || bits_q[8] !== 1'b1) begin bad++; $display("FAIL nack_slot got_n=%0d exp=1 high", bits_q.size()); end
    total++; if (bits_byte() !== 8'h40) begin bad++; $display("FAIL nack_bits got=%h exp=40", bits_byte()); end
    p0 = stop_cnt;
    send_cmd(C_STOP, 8'h00, 1'b0, lat, wn, rdy);
    total++; if (lat !== 18) begin bad++; $display("FAIL stop_lat got=%0d exp=18", lat); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stop_busy got=%b exp=0", busy); end
    total++; if (stop_cnt - p0 !== 1) begin bad++; $display("FAIL stop_cond got=%0d exp=1", stop_cnt - p0); end
    total++; if ({scl_o, sda_o} !== 2'b11) begin bad++; $display("FAIL stop_lines got=%b exp=11", {scl_o, sda_o}); end
  endtask

  task automatic test_read_restart();
    int lat, wn, s0; logic rdy;
    send_cmd(C_START, 8'h00, 1'b0, lat, wn, rdy);
    arm(2, 8'hA5, 1'b0);
    send_cmd(C_READ, 8'h00, 1'b1, lat, wn, rdy);
    total++; if (lat !== 162) begin bad++; $display("FAIL read_lat got=%0d exp=162", lat); end
    total++; if (rsp_data !== 8'hA5) begin bad++; $display("FAIL read_data got=%h exp=a5", rsp_data); end
    total++; if (rsp_ack !== 1'b0) begin bad++; $display("FAIL read_ack got=%b exp=0", rsp_ack); end
    total++; if (bits_q.size() < 9 || bits_q[8] !== 1'b1) begin bad++; $display("FAIL read_nack_slot got_n=%0d exp=1 high", bits_q.size()); end
    total++; if (sda_o !== 1'b1) begin bad++; $display("FAIL read_nack_hold got=%b exp=1", sda_o); end
    s0 = start_cnt;
    send_cmd(C_START, 8'h00, 1'b0, lat, wn, rdy);
    total++; if (lat !== 18) begin bad++; $display("FAIL rstart_lat got=%0d exp=18", lat); end
    total++; if (start_cnt - s0 !== 1) begin bad++; $display("FAIL rstart_cond got=%0d exp=1", start_cnt - s0); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstart_busy got=%b exp=1", busy); end
    arm(2, 8'h3C, 1'b0);
    send_cmd(C_READ, 8'h00, 1'b0, lat, wn, rdy);
    total++; if (rsp_data !== 8'h3C) begin bad++; $display("FAIL read2_data got=%h exp=3c", rsp_data); end
    total++; if (bits_q.size() < 9 || bits_q[8] !== 1'b0) begin bad++; $display("FAIL read2_ack_slot got_n=%0d exp=0 low", bits_q.size()); end
    total++; if (sda_o !== 1'b0) begin bad++; $display("FAIL read2_ack_hold got=%b exp=0", sda_o); end
    arm(1, 8'h00, 1'b0);
    send_cmd(C_WRITE, 8'h94, 1'b0, lat, wn, rdy);
    total++; if (rsp_ack !== 1'b1) begin bad++; $display("FAIL write3_ack got=%b exp=1", rsp_ack); end
    total++; if (rsp_data !== 8'h3C) begin bad++; $display("FAIL data_hold got=%h exp=3c", rsp_data); end
  endtask

  task automatic test_stretch_back_to_back();
    int lat, wn; logic rdy;
    arm(1, 8'h00, 1'b1);
    send_cmd(C_WRITE, 8'h94, 1'b0, lat, wn, rdy);
    total++; if (lat !== 212) begin bad++; $display("FAIL stretch_lat got=%0d exp=212", lat); end
    total++; if (rsp_ack !== 1'b1) begin bad++; $display("FAIL stretch_ack got=%b exp=1", rsp_ack); end
    total++; if (bits_byte() !== 8'h94) begin bad++; $display("FAIL stretch_bits got=%h exp=94", bits_byte()); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL done_ready got=%b exp=1", cmd_ready); end
    send_cmd(C_STOP, 8'h00, 1'b0, lat, wn, rdy);
    total++; if (wn !== 0) begin bad++; $display("FAIL b2b_accept wait got=%0d exp=0", wn); end
    total++; if (lat !== 18) begin bad++; $display("FAIL b2b_stop_lat got=%0d exp=18", lat); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid_read();
    int lat, wn; logic rdy; logic seen;
    send_cmd(C_START, 8'h00, 1'b0, lat, wn, rdy);
    arm(2, 8'hC3, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd = C_READ; cmd_nack = 1'b0;
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (37) @(posedge clk);
    #2;
    total++; if (scl_o !== 1'b0) begin bad++; $display("FAIL mid_read_scl got=%b exp=0", scl_o); end
    #1 reset = 1'b1;
    #1;
    total++; if ({scl_o, sda_o} !== 2'b11) begin bad++; $display("FAIL async_rst_lines got=%b exp=11", {scl_o, sda_o}); end
    total++; if ({cmd_ready, rsp_valid, busy} !== 3'b100) begin bad++; $display("FAIL async_rst_ctrl got=%b exp=100", {cmd_ready, rsp_valid, busy}); end
    total++; if (rsp_data !== 8'h00) begin bad++; $display("FAIL async_rst_data got=%h exp=00", rsp_data); end
    arm(0, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (rsp_valid) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL dropped_rsp got=%b exp=0", seen); end
    send_cmd(C_START, 8'h00, 1'b0, lat, wn, rdy);
    total++; if (lat !== 18) begin bad++; $display("FAIL post_rst_start_lat got=%0d exp=18", lat); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL post_rst_busy got=%b exp=1", busy); end
    send_cmd(C_STOP, 8'h00, 1'b0, lat, wn, rdy);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_rst_stop got=%b exp=0", busy); end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; cmd_valid = 1'b0; cmd = C_START; cmd_data = 8'h00; cmd_nack = 1'b0;
    resp_mode = 0; resp_byte = 8'h00; rcnt = 0; drv_idx = 0; stretch_en = 1'b0;
    test_reset();
    test_idle_cmd(C_WRITE, "write");
    test_start_write_ack();
    test_write_nack_stop();
    test_read_restart();
    test_stretch_back_to_back();
    test_idle_cmd(C_STOP, "stop");
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_master_ctrl.md
# i2c_master_ctrl

Byte-level I2C controller that drives the two-wire bus from the other end of our I2C LED responder. It lets on-chip logic or a test harness issue START, WRITE-byte, READ-byte and STOP commands over a valid/ready handshake. It generates open-drain SCL/SDA with clock-stretching support and returns the ACK status or the read data per command. It sits next to the top-level IO mapping and shares the same open-drain pin convention: `_o` low drives the line low, `_o` high releases it.

## Interface
Parameters:
- `CLK_DIV`, default 16: clk cycles per SCL quarter-period (SCL ≈ clk/(4·CLK_DIV)); legal range ≥ 2.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd`  in  2  00 START, 01 WRITE, 10 READ, 11 STOP.
- `cmd_data`  in  8  byte to send on WRITE.
- `cmd_nack`  in  1  READ only: 1 sends NACK, 0 sends ACK.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_data`  out  8  byte received by READ; held until the next READ completes.
- `rsp_ack`  out  1  WRITE: 1 if the responder ACKed; 0 for all other commands.
- `busy`  out  1  bus owned (between START and STOP completion).
- `scl_i`, `sda_i`  in  1  line levels from pads.
- `scl_o`, `sda_o`  out  1  0 drives the line low, 1 releases it.

## Operation
- Reset values: `scl_o`=1, `sda_o`=1, `cmd_ready`=1, `rsp_valid`=0, `rsp_data`=0, `rsp_ack`=0, `busy`=0. Reset also clears the FSM, the quarter counter and the bit counter.
- `scl_i` and `sda_i` each pass through a 2-FF synchronizer. All line sampling uses the synchronized values.
- A command is accepted on a clk edge where `cmd_valid`&&`cmd_ready`. The controller latches `cmd`, `cmd_data` and `cmd_nack` on that edge and drops `cmd_ready` on the next cycle.
- FSM states: IDLE, START_Q0..Q3, BIT_P0..P3, STOP_Q0..Q3, DONE.
- A "released" quarter (START_Q1, BIT_P1, STOP_Q1) sets `scl_o`=1. Its counter advances only in cycles where synchronized SCL=1, which implements clock stretching with no timeout. All other quarters last exactly `CLK_DIV` cycles.
- START:
  - Q0: `sda_o`=1, `scl_o` unchanged.
  - Q1: release SCL.
  - Q2: `sda_o`=0.
  - Q3: `scl_o`=0.
  - Then `busy`=1. A START issued while `busy`=1 is a repeated START.
- Bit (9 per byte, MSB first, 9th is the ACK slot):
  - P0: `scl_o`=0, update SDA.
  - P1: release SCL.
  - P2: SCL high; sample SDA in the last cycle of P2.
  - P3: `scl_o`=0.
- WRITE: bits 0-7 drive `cmd_data[7-i]`; the ACK slot releases SDA; `rsp_ack` = !sampled SDA.
- READ: bits 0-7 release SDA and shift sampled values into `rsp_data`. The ACK slot drives `sda_o` = `cmd_nack`.
- After a byte, SCL is low and SDA keeps its ACK-slot value.
- STOP:
  - Q0: `sda_o`=0, `scl_o`=0.
  - Q1: release SCL.
  - Q2: hold SDA low.
  - Q3: `sda_o`=1.
  - Then `busy`=0.
- WRITE, READ or STOP while `busy`=0 causes no bus activity. `rsp_valid` pulses on the cycle after acceptance with `rsp_ack`=0 and `rsp_data` unchanged.
- DONE is one cycle: `rsp_valid`=1 and `cmd_ready`=1 in the same cycle, so back-to-back acceptance is allowed.

## Timing
- Unstretched durations (each released quarter adds 2 sync cycles):
  - START/STOP: 4·CLK_DIV+2 cycles.
  - Byte: 36·CLK_DIV+18 cycles.
  - `rsp_valid` is high exactly that many cycles after the acceptance edge.
- The first line change appears on `scl_o`/`sda_o` the cycle after acceptance.
- Stretching: each cycle that synchronized SCL stays low during a released quarter adds exactly one cycle to completion.
- SDA changes only while `scl_o`=0, except the START Q2 and STOP Q3 edges.
- When `reset` asserts mid-command, `scl_o`/`sda_o` release immediately (asynchronously). The in-flight command is dropped with no `rsp_valid`, and `busy`=0.
- `cmd_valid` held while `cmd_ready`=0 is not accepted. Command inputs may change freely until acceptance.

## Test plan
- Reset: assert `reset` asynchronously mid-clock -> all outputs take reset values within the same cycle; `cmd_ready`=1.
- CLK_DIV=4, responder model at 0x4A: START, WRITE 0x94 -> SDA bits 1,0,0,1,0,1,0,0 sampled on SCL rising edges; `rsp_ack`=1; `rsp_valid` 162 cycles after WRITE acceptance; START completes in 18 cycles.
- WRITE 0x40 (no device at that address) -> ACK slot reads 1, `rsp_ack`=0; then STOP -> SDA rises while SCL high, `busy`=0.
- READ with responder returning 0xA5, `cmd_nack`=1 -> `rsp_data`=0xA5; SDA released in the ACK slot; repeated START then proceeds correctly.
- Responder holds SCL low 50 cycles past release in bit 3 of a WRITE -> completion exactly 50 cycles later than unstretched; data and ACK intact.
- WRITE with `busy`=0 -> `rsp_valid` one cycle after acceptance, `rsp_ack`=0, no line toggles. `reset` during a READ -> lines released, next START behaves normally.
